// File: rtl/rx_cgs_sync.sv
// JESD204B receive code-group synchronisation with SYNC~ generation.
// Optional SYNC~ error-report pulse is built when RX_SYNC_ERR_REPORT_EN is defined.
module rx_cgs_sync #(
    parameter int K_THRESH           = 4,
    parameter int CHK_INVALID_THRESH = 4,
    parameter int CHK_VALID_THRESH   = 4,
    parameter int ERR_PULSE_CYC      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_k,
    input  logic       i_vld,
    input  logic       i_disp_err,
    input  logic       i_nit,
    input  logic       i_lmfc_edge,
    input  logic       i_resync,
    output logic       o_sync_n,
    output logic       o_cgs_done,
    output logic [1:0] o_state,
    output logic [7:0] o_err_cnt
);

    // state    | meaning
    // CS_INIT  | hunting for K_THRESH consecutive /K/, SYNC~ held low
    // CS_CHECK | invalid characters seen, deciding between CS_DATA and CS_INIT
    // CS_DATA  | synchronised, SYNC~ released on the next LMFC boundary
    typedef enum logic [1:0] {
        CS_INIT  = 2'd0,
        CS_CHECK = 2'd1,
        CS_DATA  = 2'd2,
        CS_BAD   = 2'd3
    } state_e;

    localparam int KW = $clog2(K_THRESH + 1);
    localparam int IW = $clog2(CHK_INVALID_THRESH + 1);
    localparam int VW = $clog2(CHK_VALID_THRESH + 1);

    state_e        state_q, state_d;
    logic [KW-1:0] kcnt_q, kcnt_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [7:0]    err_q, err_d;
    logic          rel_q, rel_d;

    logic invalid, kchar, char_bad, cgs_done, base_sync;

    assign invalid   = i_disp_err | i_nit;
    assign kchar     = i_k & (i_data == 8'hBC) & ~invalid;
    assign char_bad  = i_vld & invalid;
    assign cgs_done  = (state_q == CS_DATA) | (state_q == CS_CHECK);
    assign base_sync = rel_q & cgs_done;

    always_comb begin
        state_d = state_q;
        kcnt_d  = kcnt_q;
        icnt_d  = icnt_q;
        vcnt_d  = vcnt_q;
        if (i_resync) begin
            state_d = CS_INIT;
            kcnt_d  = '0;
            icnt_d  = '0;
            vcnt_d  = '0;
        end else begin
            case (state_q)
                CS_INIT: begin
                    if (i_vld) begin
                        if (!kchar) begin
                            kcnt_d = '0;
                        end else if (kcnt_q == KW'(K_THRESH - 1)) begin
                            state_d = CS_DATA;
                            kcnt_d  = '0;
                        end else begin
                            kcnt_d = kcnt_q + 1'b1;
                        end
                    end
                end
                CS_DATA: begin
                    if (char_bad) begin
                        state_d = CS_CHECK;
                        icnt_d  = IW'(1);
                        vcnt_d  = '0;
                    end
                end
                CS_CHECK: begin
                    if (char_bad) begin
                        vcnt_d = '0;
                        if (icnt_q >= IW'(CHK_INVALID_THRESH - 1)) begin
                            state_d = CS_INIT;
                            icnt_d  = '0;
                        end else begin
                            icnt_d = icnt_q + 1'b1;
                        end
                    end else if (i_vld) begin
                        if (vcnt_q == VW'(CHK_VALID_THRESH - 1)) begin
                            state_d = CS_DATA;
                            icnt_d  = '0;
                            vcnt_d  = '0;
                        end else begin
                            vcnt_d = vcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = CS_INIT;
                    kcnt_d  = '0;
                    icnt_d  = '0;
                    vcnt_d  = '0;
                end
            endcase
        end
    end

    // Edge must be seen while already synchronised; an edge on the final /K/ is ignored.
    always_comb begin
        rel_d = rel_q | (cgs_done & i_lmfc_edge);
        if (state_d == CS_INIT) begin
            rel_d = 1'b0;
        end
        err_d = err_q;
        if (char_bad && cgs_done && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CS_INIT;
            kcnt_q  <= '0;
            icnt_q  <= '0;
            vcnt_q  <= '0;
            err_q   <= '0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kcnt_q  <= kcnt_d;
            icnt_q  <= icnt_d;
            vcnt_q  <= vcnt_d;
            err_q   <= err_d;
            rel_q   <= rel_d;
        end
    end

`ifdef RX_SYNC_ERR_REPORT_EN
    localparam int PW = $clog2(ERR_PULSE_CYC + 1);

    logic [PW-1:0] pulse_q, pulse_d;

    // Down-counter; a new pulse starts only while SYNC~ is currently high.
    always_comb begin
        pulse_d = pulse_q;
        if (state_d == CS_INIT) begin
            pulse_d = '0;
        end else if (pulse_q != '0) begin
            pulse_d = pulse_q - 1'b1;
        end else if (char_bad && base_sync) begin
            pulse_d = PW'(ERR_PULSE_CYC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign o_sync_n = base_sync & (pulse_q == '0);
`else
    assign o_sync_n = base_sync;
`endif

    assign o_cgs_done = cgs_done;
    assign o_state    = state_q;
    assign o_err_cnt  = err_q;

endmodule

// File: tb/tb_rx_cgs_sync.sv
// Self-checking bench for rx_cgs_sync: directed vector table, saturation run,
// then randomized traffic compared against a behavioural model.
module tb_rx_cgs_sync;

    localparam int K_THRESH           = 4;
    localparam int CHK_INVALID_THRESH = 4;
    localparam int CHK_VALID_THRESH   = 4;
    localparam int ERR_PULSE_CYC      = 2;
`ifdef RX_SYNC_ERR_REPORT_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    typedef struct {
        bit         rst;
        logic [7:0] data;
        bit         k;
        bit         vld;
        bit         de;
        bit         nit;
        bit         lmfc;
        bit         resync;
        int         e_state;
        bit         e_sync;
        bit         e_done;
        int         e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_k = 1'b0;
    logic       i_vld = 1'b0;
    logic       i_disp_err = 1'b0;
    logic       i_nit = 1'b0;
    logic       i_lmfc_edge = 1'b0;
    logic       i_resync = 1'b0;
    logic       o_sync_n;
    logic       o_cgs_done;
    logic [1:0] o_state;
    logic [7:0] o_err_cnt;

    int n_pass = 0;
    int n_total = 0;

    rx_cgs_sync #(
        .K_THRESH          (K_THRESH),
        .CHK_INVALID_THRESH(CHK_INVALID_THRESH),
        .CHK_VALID_THRESH  (CHK_VALID_THRESH),
        .ERR_PULSE_CYC     (ERR_PULSE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .i_k        (i_k),
        .i_vld      (i_vld),
        .i_disp_err (i_disp_err),
        .i_nit      (i_nit),
        .i_lmfc_edge(i_lmfc_edge),
        .i_resync   (i_resync),
        .o_sync_n   (o_sync_n),
        .o_cgs_done (o_cgs_done),
        .o_state    (o_state),
        .o_err_cnt  (o_err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: link status tracked as plain integers.
    int m_state = 0;
    int m_k = 0;
    int m_i = 0;
    int m_v = 0;
    int m_err = 0;
    int m_pulse = 0;
    bit m_rel = 1'b0;

    function automatic bit m_sync();
        return (m_state != 0) && m_rel && (m_pulse == 0);
    endfunction

    task automatic model_step(input vec_t v);
        bit inv, kc, cur, nr;
        int ns, nk, ni, nv, np, ne;
        inv = v.de | v.nit;
        kc  = v.k && (v.data == 8'hBC) && !inv;
        cur = m_sync();
        ns = m_state; nk = m_k; ni = m_i; nv = m_v; np = m_pulse; ne = m_err;
        if (v.rst) begin
            m_state = 0; m_k = 0; m_i = 0; m_v = 0; m_err = 0; m_pulse = 0; m_rel = 0;
            return;
        end
        if (v.vld && inv && m_state != 0) ne = (m_err < 255) ? m_err + 1 : 255;
        if (v.resync) begin
            ns = 0; nk = 0; ni = 0; nv = 0;
        end else if (v.vld) begin
            if (m_state == 0) begin
                if (kc) begin
                    nk = m_k + 1;
                    if (nk == K_THRESH) begin ns = 2; nk = 0; end
                end else begin
                    nk = 0;
                end
            end else if (m_state == 2) begin
                if (inv) begin ns = 1; ni = 1; nv = 0; end
            end else if (inv) begin
                ni = m_i + 1; nv = 0;
                if (ni >= CHK_INVALID_THRESH) begin ns = 0; ni = 0; end
            end else begin
                nv = m_v + 1;
                if (nv == CHK_VALID_THRESH) begin ns = 2; ni = 0; nv = 0; end
            end
        end
        nr = m_rel || (m_state != 0 && v.lmfc);
        if (PE) begin
            if (m_pulse > 0) np = m_pulse - 1;
            else if (v.vld && inv && cur) np = ERR_PULSE_CYC;
        end
        if (ns == 0) begin nr = 0; np = 0; end
        m_state = ns; m_k = nk; m_i = ni; m_v = nv; m_pulse = np; m_err = ne; m_rel = nr;
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; i_data = v.data; i_k = v.k; i_vld = v.vld;
        i_disp_err = v.de; i_nit = v.nit; i_lmfc_edge = v.lmfc; i_resync = v.resync;
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t row(input string kind, input int st, input bit sy,
                                 input bit dn, input int er);
        vec_t v = '{default: 0};
        case (kind)
            "R":  v.rst = 1;
            "K":  begin v.vld = 1; v.k = 1; v.data = 8'hBC; end
            "KL": begin v.vld = 1; v.k = 1; v.data = 8'hBC; v.lmfc = 1; end
            "D":  begin v.vld = 1; v.data = 8'h55; end
            "N":  begin v.vld = 1; v.nit = 1; v.data = 8'h55; end
            "L":  v.lmfc = 1;
            "S":  v.resync = 1;
            default: ;
        endcase
        v.e_state = st; v.e_sync = sy; v.e_done = dn; v.e_err = er;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // first lock, release on a later LMFC edge
        tbl.push_back(row("R", 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(row("K", 0, 0, 0, 0));
        tbl.push_back(row("K", 2, 0, 1, 0));
        for (int i = 0; i < 9; i++) tbl.push_back(row("I", 2, 0, 1, 0));
        tbl.push_back(row("L", 2, 1, 1, 0));
        // broken /K/ run restarts the count; edge on the 4th /K/ ignored
        tbl.push_back(row("R", 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(row("K", 0, 0, 0, 0));
        tbl.push_back(row("D", 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(row("K", 0, 0, 0, 0));
        tbl.push_back(row("KL", 2, 0, 1, 0));
        tbl.push_back(row("I", 2, 0, 1, 0));
        tbl.push_back(row("L", 2, 1, 1, 0));
        // one invalid then recovery through CS_CHECK
        tbl.push_back(row("N", 1, !PE, 1, 1));
        tbl.push_back(row("D", 1, !PE, 1, 1));
        tbl.push_back(row("D", 1, 1, 1, 1));
        tbl.push_back(row("D", 1, 1, 1, 1));
        tbl.push_back(row("D", 2, 1, 1, 1));
        // four invalids lose sync
        tbl.push_back(row("R", 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(row("K", 0, 0, 0, 0));
        tbl.push_back(row("K", 2, 0, 1, 0));
        tbl.push_back(row("L", 2, 1, 1, 0));
        tbl.push_back(row("N", 1, !PE, 1, 1));
        tbl.push_back(row("N", 1, !PE, 1, 2));
        tbl.push_back(row("N", 1, 1, 1, 3));
        tbl.push_back(row("N", 0, 0, 0, 4));
        // resync keeps the error count
        for (int i = 0; i < 3; i++) tbl.push_back(row("K", 0, 0, 0, 4));
        tbl.push_back(row("K", 2, 0, 1, 4));
        tbl.push_back(row("L", 2, 1, 1, 4));
        tbl.push_back(row("S", 0, 0, 0, 4));

        @(negedge clk);
        foreach (tbl[i]) begin
            apply(tbl[i]);
            check($sformatf("tbl%0d_state", i), int'(o_state), tbl[i].e_state);
            check($sformatf("tbl%0d_sync_n", i), int'(o_sync_n), int'(tbl[i].e_sync));
            check($sformatf("tbl%0d_cgs_done", i), int'(o_cgs_done), int'(tbl[i].e_done));
            check($sformatf("tbl%0d_err_cnt", i), int'(o_err_cnt), tbl[i].e_err);
        end

        // 75 lock/lose runs of 4 invalids each: 300 more invalids, count pins at 255
        for (int r = 0; r < 75; r++) begin
            int exp_err;
            for (int i = 0; i < 4; i++) apply(row("K", 0, 0, 0, 0));
            for (int i = 0; i < 4; i++) apply(row("N", 0, 0, 0, 0));
            exp_err = 4 + 4 * (r + 1);
            if (exp_err > 255) exp_err = 255;
            check($sformatf("sat%0d_err_cnt", r), int'(o_err_cnt), exp_err);
            check($sformatf("sat%0d_state", r), int'(o_state), 0);
        end

        // randomized traffic against the model
        apply(row("R", 0, 0, 0, 0));
        for (int c = 0; c < 4000; c++) begin
            vec_t v = '{default: 0};
            int r;
            logic [1:0] e;
            v.vld = ($urandom_range(0, 99) < 85);
            r = $urandom_range(0, 99);
            if (r < 70) begin
                v.k = 1; v.data = 8'hBC;
            end else if (r < 80) begin
                e = 2'($urandom_range(1, 3));
                v.de = e[0]; v.nit = e[1];
                v.k = 1'($urandom_range(0, 1));
                v.data = v.k ? 8'hBC : 8'($urandom);
            end else begin
                v.k = 1'($urandom_range(0, 1));
                v.data = $urandom_range(0, 1) ? 8'hBC : 8'($urandom);
            end
            v.lmfc   = ($urandom_range(0, 7) == 0);
            v.resync = ($urandom_range(0, 199) == 0);
            v.rst    = ($urandom_range(0, 999) == 0);
            apply(v);
            check("rnd_state", int'(o_state), m_state);
            check("rnd_sync_n", int'(o_sync_n), int'(m_sync()));
            check("rnd_cgs_done", int'(o_cgs_done), int'(m_state != 0));
            check("rnd_err_cnt", int'(o_err_cnt), m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rx_cgs_sync.md
Name: rx_cgs_sync

Overview:
- Receive-side counterpart of the TX link's SYNC~ handling. Runs the JESD204B code-group-synchronisation (CGS) state machine on decoded 8b/10b characters.
- Drives SYNC~ back to the transmitter, releasing it on an LMFC boundary once CGS is complete.
- Sits between the RX 8b/10b decoder and the RX link-layer frame/ILA logic, in the device-clock domain.

Parameters:
K_THRESH, 4, consecutive valid /K/ (K28.5) characters needed in CS_INIT to declare CGS complete
CHK_INVALID_THRESH, 4, invalid characters counted in CS_CHECK before falling back to CS_INIT
CHK_VALID_THRESH, 4, consecutive valid characters in CS_CHECK needed to return to CS_DATA
ERR_PULSE_CYC, 2, SYNC~ error-report pulse length in clk cycles (optional feature only)

Ports:
clk  in  1  device clock; all logic on rising edge
rst  in  1  synchronous active-high reset
i_data  in  8  decoded character
i_k  in  1  character is a control (K) symbol
i_vld  in  1  character qualifier; all other character inputs are ignored when 0
i_disp_err  in  1  running-disparity error on this character
i_nit  in  1  not-in-table error on this character
i_lmfc_edge  in  1  single-cycle pulse marking an LMFC boundary
i_resync  in  1  forces re-synchronisation (link-layer request)
o_sync_n  out  1  SYNC~ to transmitter; active low
o_cgs_done  out  1  1 while in CS_DATA or CS_CHECK
o_state  out  2  0=CS_INIT, 1=CS_CHECK, 2=CS_DATA
o_err_cnt  out  8  saturating count of invalid characters seen in CS_DATA/CS_CHECK

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - state=CS_INIT; o_sync_n=0; o_cgs_done=0; o_err_cnt=0.
  - Internal counters (kcnt, icnt, vcnt) cleared; pulse timer cleared.
- Character classes, evaluated only when i_vld=1:
  - invalid = i_disp_err | i_nit.
  - kchar = i_k & (i_data==8'hBC) & !invalid.
  - valid = !invalid.
- i_vld=0 cycles: hold all counters and state.
- CS_INIT:
  - kchar increments kcnt; any other valid-qualified character clears kcnt.
  - When kcnt would reach K_THRESH: next state CS_DATA, kcnt cleared.
  - o_cgs_done rises the cycle after the K_THRESH-th /K/.
- CS_DATA:
  - An invalid character moves to CS_CHECK next cycle, with icnt=1 and vcnt=0.
- CS_CHECK:
  - Invalid: icnt++, vcnt=0. When icnt reaches CHK_INVALID_THRESH: go to CS_INIT.
  - Valid: vcnt++. When vcnt reaches CHK_VALID_THRESH: go to CS_DATA and clear icnt/vcnt.
- SYNC~:
  - Held 0 in CS_INIT.
  - Once the registered state is CS_DATA or CS_CHECK, the first i_lmfc_edge sets o_sync_n=1 on the following cycle.
  - An i_lmfc_edge in the same cycle as the 4th /K/ does not count; the next edge releases it.
  - Once released, o_sync_n stays 1 in CS_DATA/CS_CHECK.
  - Re-entering CS_INIT drives o_sync_n=0 in the same cycle that o_state shows CS_INIT.
- i_resync=1:
  - Highest priority below rst.
  - Next cycle: state CS_INIT, kcnt/icnt/vcnt cleared, o_sync_n=0.
  - o_err_cnt is not cleared.
- o_err_cnt:
  - Increments on each invalid character while in CS_DATA/CS_CHECK.
  - Saturates at 255; never wraps.
- State 3 is unreachable; if entered, go to CS_INIT.

Optional Feature:
- Macro: RX_SYNC_ERR_REPORT_EN.
- When defined:
  - While o_sync_n=1, an invalid character drives o_sync_n=0 for exactly ERR_PULSE_CYC cycles, starting the next cycle.
  - The state machine and counters are unaffected.
  - Invalid characters during an active pulse neither extend nor restart it.
  - Entering CS_INIT overrides the pulse, holding SYNC~ low.
- When undefined: o_sync_n reflects CGS status only, and the pulse timer is not built.

Test Plan:
- rst then 4 cycles of i_vld=1, i_k=1, i_data=BC; i_lmfc_edge 10 cycles later -> o_cgs_done=1 after the 4th /K/; o_sync_n rises the cycle after the edge; o_state=2.
- 3x BC, 1x data 0x55, 4x BC -> CGS completes only after the second run of 4; kcnt reset verified.
- In CS_DATA: 1 invalid, then 4 valid -> CS_CHECK then back to CS_DATA; o_sync_n stays 1; o_err_cnt=1.
- In CS_DATA: 4 consecutive i_nit=1 -> CS_INIT after the 4th; o_sync_n=0; o_err_cnt=4.
- i_resync pulse in CS_DATA, plus 300 invalid characters across runs -> state 0, o_sync_n=0 next cycle; o_err_cnt saturates at 255.
- RX_SYNC_ERR_REPORT_EN defined: one invalid in CS_DATA -> o_sync_n low for exactly 2 cycles; a second invalid inside the pulse gives no extension.
